// File: rtl/iterative_unsigned_divider_pkg.sv
// Shared definitions for the iterative arithmetic units: FSM state encodings
// and a constant-evaluable clog2 for sizing counters.
package iterative_unsigned_divider_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY,
    DONE = ST_DONE
  } state_e;

  function automatic int clog2_const(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/Register.sv
// Generic datapath register with clock enable and synchronous clear,
// plus an asynchronous active-low clear that has priority over both.
module Register #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             clock_enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_d,
  output logic [WIDTH-1:0] data_q
);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      data_q <= '0;
    end else if (clear) begin
      data_q <= '0;
    end else if (clock_enable) begin
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/divider_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// then conditionally subtract the divisor.
module divider_step #(
  parameter int WORD_WIDTH = 8
) (
  input  logic [WORD_WIDTH-1:0] rem_i,
  input  logic                  dvd_msb_i,
  input  logic [WORD_WIDTH-1:0] divisor_i,
  output logic [WORD_WIDTH-1:0] rem_o,
  output logic                  q_bit_o
);

  logic [WORD_WIDTH:0] trial;

  // The trial value is W+1 bits; a set top bit already exceeds any divisor, and
  // the true difference is below the divisor, so a W-bit subtract is exact.
  always_comb begin
    trial   = {rem_i, dvd_msb_i};
    q_bit_o = trial[WORD_WIDTH] || (trial[WORD_WIDTH-1:0] >= divisor_i);
    rem_o   = q_bit_o ? (trial[WORD_WIDTH-1:0] - divisor_i) : trial[WORD_WIDTH-1:0];
  end

endmodule

// File: rtl/iterative_unsigned_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle, with ready/valid
// handshakes; holds a single result until the downstream side takes it.
module iterative_unsigned_divider
  import iterative_unsigned_divider_pkg::*;
#(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic [WORD_WIDTH-1:0] input_dividend,
  input  logic [WORD_WIDTH-1:0] input_divisor,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [WORD_WIDTH-1:0] output_quotient,
  output logic [WORD_WIDTH-1:0] output_remainder,
  output logic                  output_divide_by_zero
);

  localparam int COUNT_WIDTH = clog2_const(WORD_WIDTH + 1);

  state_e state_q, state_d;

  logic                   accept, step, finish;
  logic [WORD_WIDTH-1:0]  dvd_q, dvd_d, dsr_q, rem_q, rem_d;
  logic [WORD_WIDTH-2:0]  quo_q;
  logic [WORD_WIDTH-1:0]  quo_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   dbz_q, q_bit;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake outputs come from the registered state only.
  always_comb begin
    state_d      = state_q;
    input_ready  = 1'b0;
    output_valid = 1'b0;
    case (state_q)
      IDLE: begin
        input_ready = 1'b1;
        if (input_valid) state_d = BUSY;
      end
      BUSY: begin
        if (cnt_q == COUNT_WIDTH'(1)) state_d = DONE;
      end
      DONE: begin
        output_valid = 1'b1;
        if (output_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  divider_step #(.WORD_WIDTH(WORD_WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[WORD_WIDTH-1]),
    .divisor_i (dsr_q),
    .rem_o     (rem_d),
    .q_bit_o   (q_bit)
  );

  // A zero divisor needs no special path: every step then sets its quotient bit
  // and the remainder accumulates the dividend unchanged.
  always_comb begin
    accept = (state_q == IDLE) && input_valid;
    step   = (state_q == BUSY);
    finish = step && (cnt_q == COUNT_WIDTH'(1));
    dvd_d  = accept ? input_dividend : {dvd_q[WORD_WIDTH-2:0], 1'b0};
    cnt_d  = accept ? COUNT_WIDTH'(WORD_WIDTH) : cnt_q - COUNT_WIDTH'(1);
    quo_d  = {quo_q, q_bit};
  end

  Register #(.WIDTH(WORD_WIDTH)) u_dvd (
    .clock(clock), .clear_n(clear_n), .clock_enable(accept || step), .clear(1'b0),
    .data_d(dvd_d), .data_q(dvd_q));

  Register #(.WIDTH(WORD_WIDTH)) u_dsr (
    .clock(clock), .clear_n(clear_n), .clock_enable(accept), .clear(1'b0),
    .data_d(input_divisor), .data_q(dsr_q));

  Register #(.WIDTH(1)) u_dbz (
    .clock(clock), .clear_n(clear_n), .clock_enable(accept), .clear(1'b0),
    .data_d(input_divisor == '0), .data_q(dbz_q));

  Register #(.WIDTH(COUNT_WIDTH)) u_cnt (
    .clock(clock), .clear_n(clear_n), .clock_enable(accept || step), .clear(1'b0),
    .data_d(cnt_d), .data_q(cnt_q));

  Register #(.WIDTH(WORD_WIDTH)) u_rem (
    .clock(clock), .clear_n(clear_n), .clock_enable(step), .clear(accept),
    .data_d(rem_d), .data_q(rem_q));

  Register #(.WIDTH(WORD_WIDTH-1)) u_quo (
    .clock(clock), .clear_n(clear_n), .clock_enable(step), .clear(accept),
    .data_d(quo_d[WORD_WIDTH-2:0]), .data_q(quo_q));

  // Separate result registers keep the last result visible while the next runs.
  Register #(.WIDTH(WORD_WIDTH)) u_res_quo (
    .clock(clock), .clear_n(clear_n), .clock_enable(finish), .clear(1'b0),
    .data_d(quo_d), .data_q(output_quotient));

  Register #(.WIDTH(WORD_WIDTH)) u_res_rem (
    .clock(clock), .clear_n(clear_n), .clock_enable(finish), .clear(1'b0),
    .data_d(rem_d), .data_q(output_remainder));

  Register #(.WIDTH(1)) u_res_dbz (
    .clock(clock), .clear_n(clear_n), .clock_enable(finish), .clear(1'b0),
    .data_d(dbz_q), .data_q(output_divide_by_zero));

endmodule

// File: tb/tb_iterative_unsigned_divider.sv
// Scoreboard bench for iterative_unsigned_divider (WORD_WIDTH=8): the driver
// pushes hand-computed results, a negedge monitor pops and compares them.
module tb_iterative_unsigned_divider;

  logic       clock = 1'b0;
  logic       clear_n = 1'b0;
  logic       input_valid = 1'b0;
  logic       output_ready = 1'b1;
  logic [7:0] input_dividend = '0;
  logic [7:0] input_divisor = '0;
  logic       input_ready, output_valid, output_divide_by_zero;
  logic [7:0] output_quotient, output_remainder;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  bit randomStall = 1'b0;
  bit prevValid = 1'b0;

  typedef struct {
    int q;
    int r;
    int d;
    int acc;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int d;
  } vec_t;
  vec_t vecs[$];

  iterative_unsigned_divider #(.WORD_WIDTH(8)) dut (
    .clock                 (clock),
    .clear_n               (clear_n),
    .input_valid           (input_valid),
    .input_ready           (input_ready),
    .input_dividend        (input_dividend),
    .input_divisor         (input_divisor),
    .output_valid          (output_valid),
    .output_ready          (output_ready),
    .output_quotient       (output_quotient),
    .output_remainder      (output_remainder),
    .output_divide_by_zero (output_divide_by_zero)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  // Stall changes land just after a rising edge so the monitor and the DUT see the same value.
  always @(posedge clock) begin
    #2;
    if (randomStall) output_ready = 1'($urandom_range(0, 1));
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int a, input int b, input int q, input int r, input int d);
    int waitCount = 0;
    @(negedge clock);
    while (!input_ready && waitCount < 200) begin
      @(negedge clock);
      waitCount++;
    end
    if (!input_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: input_ready stayed 0 for %0d a=%0d b=%0d", waitCount, a, b);
      return;
    end
    input_dividend = 8'(a);
    input_divisor  = 8'(b);
    input_valid    = 1'b1;
    @(posedge clock);
    #1;
    sbq.push_back('{q, r, d, cycle});
    input_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: %0d results outstanding, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  // Monitor: compares the presented result against the oldest expectation every
  // cycle it is valid (covers hold stability), and pops on a handshake.
  always @(negedge clock) begin
    if (clear_n && output_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_valid: got output_valid=1 q=%0d r=%0d, expected no result",
                 output_quotient, output_remainder);
      end else begin
        if (!prevValid) checkOutput("latency", cycle - sbq[0].acc, 8);
        checkOutput("quotient", int'(output_quotient), sbq[0].q);
        checkOutput("remainder", int'(output_remainder), sbq[0].r);
        checkOutput("divide_by_zero", int'(output_divide_by_zero), sbq[0].d);
        checkOutput("input_ready_in_done", int'(input_ready), 0);
        if (output_ready) void'(sbq.pop_front());
      end
    end
    prevValid = output_valid;
  end

  initial begin
    $display("[TB] start");
    #3;
    checkOutput("reset_input_ready", int'(input_ready), 1);
    checkOutput("reset_output_valid", int'(output_valid), 0);
    checkOutput("reset_quotient", int'(output_quotient), 0);
    checkOutput("reset_remainder", int'(output_remainder), 0);
    checkOutput("reset_dbz", int'(output_divide_by_zero), 0);
    @(negedge clock);
    clear_n = 1'b1;

    applyStimulus(100, 7, 14, 2, 0);
    applyStimulus(55, 0, 255, 55, 1);
    drain();

    // Long output stall: result must be held and no new operands accepted.
    @(posedge clock);
    #1 output_ready = 1'b0;
    applyStimulus(200, 3, 66, 2, 0);
    repeat (20) @(negedge clock);
    checkOutput("stall_output_valid", int'(output_valid), 1);
    checkOutput("stall_input_ready", int'(input_ready), 0);
    @(posedge clock);
    #1 output_ready = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("release_idle_ready", int'(input_ready), 1);
    checkOutput("release_output_valid", int'(output_valid), 0);
    checkOutput("release_held_quotient", int'(output_quotient), 66);

    applyStimulus(255, 1, 255, 0, 0);
    applyStimulus(0, 9, 0, 0, 0);
    applyStimulus(9, 10, 0, 9, 0);
    drain();

    // Reset after four steps aborts the division without presenting anything.
    applyStimulus(77, 6, 12, 5, 0);
    repeat (4) @(posedge clock);
    #1 clear_n = 1'b0;
    #1;
    checkOutput("abort_output_valid", int'(output_valid), 0);
    checkOutput("abort_input_ready", int'(input_ready), 1);
    checkOutput("abort_quotient", int'(output_quotient), 0);
    sbq.delete();
    #1 clear_n = 1'b1;
    repeat (12) @(negedge clock);
    applyStimulus(13, 5, 2, 3, 0);
    drain();

    vecs.push_back('{250, 16, 15, 10, 0});
    vecs.push_back('{128, 128, 1, 0, 0});
    vecs.push_back('{127, 255, 0, 127, 0});
    vecs.push_back('{254, 2, 127, 0, 0});
    vecs.push_back('{1, 0, 255, 1, 1});
    vecs.push_back('{0, 0, 255, 0, 1});
    vecs.push_back('{99, 9, 11, 0, 0});
    vecs.push_back('{201, 13, 15, 6, 0});
    vecs.push_back('{255, 200, 1, 55, 0});
    vecs.push_back('{200, 255, 0, 200, 0});
    randomStall = 1'b1;
    foreach (vecs[i]) applyStimulus(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].d);
    drain();
    randomStall = 1'b0;
    output_ready = 1'b1;
    repeat (3) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
